// File: rtl/fp32_pkg.sv
// Shared binary32 definitions for the FP arithmetic stage: field layout,
// opcode encoding and the final saturate/pack helper.
package fp32_pkg;

  localparam int FP_BIAS    = 127;
  localparam int FP_EXP_MAX = 255;
  localparam int FP_FRAC_W  = 23;
  localparam int FP_EXP_W   = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_FRAC_W-1:0] frac;
  } fp32_t;

  // Returns {overflow, word}: saturate to inf above 254, flush to +0 at or below 0.
  function automatic logic [32:0] fp_pack(input logic sign,
                                          input logic signed [9:0] exp,
                                          input logic [22:0] frac);
    logic [32:0] word;
    if (int'(exp) >= FP_EXP_MAX) begin
      word = {1'b1, sign, 8'hFF, 23'd0};
    end else if (int'(exp) <= 32'sd0) begin
      word = 33'd0;
    end else begin
      word = {1'b0, sign, exp[7:0], frac};
    end
    return word;
  endfunction

endpackage

// File: rtl/fp_normalize.sv
// Renormalizes a 25-bit add/sub magnitude: one-bit right shift on carry-out,
// otherwise leading-zero count and left shift with exponent decrement.
module fp_normalize
  import fp32_pkg::*;
(
  input  logic [24:0]       mag,
  input  logic signed [9:0] exp_in,
  output logic [22:0]       frac,
  output logic signed [9:0] exp_out,
  output logic              is_zero
);

  logic [9:0] lz;

  // Leading-zero count below the carry bit; the highest set bit wins.
  always_comb begin
    lz = 10'd0;
    for (int i = 0; i < 24; i++) begin
      if (mag[i]) begin
        lz = 10'(23 - i);
      end else begin
        lz = lz;
      end
    end
  end

  // The leading one is shifted out of the 23-bit window, leaving the fraction.
  always_comb begin
    if (mag[24]) begin
      frac    = mag[23:1];
      exp_out = exp_in + 10'sd1;
    end else begin
      frac    = mag[22:0] << lz;
      exp_out = exp_in - $signed(lz);
    end
  end

  assign is_zero = (mag == 25'd0);

endmodule

// File: rtl/floating_point_alu.sv
// Single-cycle binary32 add/multiply stage with truncating rounding,
// flush-to-zero underflow and a registered overflow flag.
module floating_point_alu
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sel,
  output logic [31:0] result,
  output logic        overflow
);

  fp32_t fa, fb;
  logic  a_zero, b_zero, a_inf, b_inf, a_ge_b;
  logic [23:0] sig_a, sig_b;

  assign fa     = a;
  assign fb     = b;
  assign a_zero = (fa.exp == 8'd0);
  assign b_zero = (fb.exp == 8'd0);
  assign a_inf  = (fa.exp == 8'hFF);
  assign b_inf  = (fb.exp == 8'hFF);
  assign sig_a  = {1'b1, fa.frac};
  assign sig_b  = {1'b1, fb.frac};
  assign a_ge_b = (a[30:0] >= b[30:0]);

  logic                big_sign;
  logic [7:0]          big_exp, exp_diff;
  logic [23:0]         big_sig, small_sig, aligned;
  logic [24:0]         add_mag;
  logic signed [9:0]   add_exp, norm_exp;
  logic [22:0]         norm_frac;
  logic                norm_zero;

  // Order operands by magnitude so subtraction never goes negative.
  always_comb begin
    if (a_ge_b) begin
      big_sign  = fa.sign;
      big_exp   = fa.exp;
      big_sig   = sig_a;
      small_sig = sig_b;
      exp_diff  = fa.exp - fb.exp;
    end else begin
      big_sign  = fb.sign;
      big_exp   = fb.exp;
      big_sig   = sig_b;
      small_sig = sig_a;
      exp_diff  = fb.exp - fa.exp;
    end
  end

  assign aligned = small_sig >> exp_diff;
  assign add_mag = (fa.sign == fb.sign) ? ({1'b0, big_sig} + {1'b0, aligned})
                                        : ({1'b0, big_sig} - {1'b0, aligned});
  assign add_exp = $signed({2'b00, big_exp});

  fp_normalize u_normalize (
    .mag     (add_mag),
    .exp_in  (add_exp),
    .frac    (norm_frac),
    .exp_out (norm_exp),
    .is_zero (norm_zero)
  );

  logic [24:0]       mul_top;
  logic signed [9:0] mul_exp;
  logic [22:0]       mul_frac;

  // Keep product bits [47:23]; bit 47 selects the one-bit renormalization.
  assign mul_top  = 25'((48'(sig_a) * 48'(sig_b)) >> 23);
  assign mul_exp  = $signed({2'b00, fa.exp}) + $signed({2'b00, fb.exp})
                  - $signed(10'(FP_BIAS)) + (mul_top[24] ? 10'sd1 : 10'sd0);
  assign mul_frac = mul_top[24] ? mul_top[23:1] : mul_top[22:0];

  logic [32:0] next_word;

  // Operation select, special operands and saturation.
  always_comb begin
    next_word = 33'd0;
    if (a_inf || b_inf) begin
      next_word = {1'b1, (sel == OP_MUL) ? (fa.sign ^ fb.sign) : big_sign, 8'hFF, 23'd0};
    end else if (sel == OP_MUL) begin
      if (a_zero || b_zero) begin
        next_word = 33'd0;
      end else begin
        next_word = fp_pack(fa.sign ^ fb.sign, mul_exp, mul_frac);
      end
    end else begin
      if (a_zero) begin
        next_word = b_zero ? 33'd0 : {1'b0, b};
      end else if (b_zero) begin
        next_word = {1'b0, a};
      end else if (norm_zero) begin
        next_word = 33'd0;
      end else begin
        next_word = fp_pack(big_sign, norm_exp, norm_frac);
      end
    end
  end

  // Output register with synchronous reset priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      result   <= 32'h0000_0000;
      overflow <= 1'b0;
    end else begin
      result   <= next_word[31:0];
      overflow <= next_word[32];
    end
  end

endmodule

// File: tb/tb_floating_point_alu.sv
// Self-checking bench for floating_point_alu: directed plan vectors plus
// randomized back-to-back operations against a value-level reference model.
module tb_floating_point_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic        sel;
  logic [31:0] result;
  logic        overflow;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  floating_point_alu dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .sel      (sel),
    .result   (result),
    .overflow (overflow)
  );

  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got ovf=%0b res=%08h, want ovf=%0b res=%08h",
               tag, got[32], got[31:0], want[32], want[31:0]);
    end
  endtask

  function automatic logic [32:0] pack(input logic s, input int e, input longint m);
    if (e >= 255) return {1'b1, s, 8'hFF, 23'd0};
    if (e <= 0)   return 33'd0;
    return {1'b0, s, e[7:0], m[22:0]};
  endfunction

  // Value-level model: significands as integers, normalize by scaling loops.
  function automatic logic [32:0] ref_model(input logic [31:0] x, input logic [31:0] y, input logic op);
    int     ex, ey, eb, es, e;
    longint mx, my, mb, ms, m;
    logic   sb;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    mx = longint'({1'b1, x[22:0]});
    my = longint'({1'b1, y[22:0]});
    if (ex == 255 || ey == 255) begin
      if (op) sb = x[31] ^ y[31];
      else    sb = (x[30:0] >= y[30:0]) ? x[31] : y[31];
      return {1'b1, sb, 8'hFF, 23'd0};
    end
    if (op) begin
      if (ex == 0 || ey == 0) return 33'd0;
      m = (mx * my) >> 23;
      e = ex + ey - 127;
      if (m >= 64'sd16777216) begin
        m = m >> 1;
        e = e + 1;
      end
      return pack(x[31] ^ y[31], e, m);
    end
    if (ex == 0) return (ey == 0) ? 33'd0 : {1'b0, y};
    if (ey == 0) return {1'b0, x};
    if (x[30:0] >= y[30:0]) begin
      eb = ex; es = ey; mb = mx; ms = my; sb = x[31];
    end else begin
      eb = ey; es = ex; mb = my; ms = mx; sb = y[31];
    end
    ms = (eb - es >= 63) ? 64'sd0 : (ms >> (eb - es));
    m  = (x[31] == y[31]) ? (mb + ms) : (mb - ms);
    if (m == 64'sd0) return 33'd0;
    e = eb;
    while (m >= 64'sd16777216) begin m = m >> 1; e = e + 1; end
    while (m <  64'sd8388608)  begin m = m << 1; e = e - 1; end
    return pack(sb, e, m);
  endfunction

  function automatic logic [31:0] rand_fp(input int near_exp);
    int r, e;
    r = int'($urandom_range(0, 99));
    if (r < 8)       e = 0;
    else if (r < 11) e = 255;
    else if (near_exp > 0 && r < 55) begin
      e = near_exp + int'($urandom_range(0, 8)) - 4;
      if (e < 1)   e = 1;
      if (e > 254) e = 254;
    end else e = int'($urandom_range(1, 254));
    return {1'($urandom_range(0, 1)), e[7:0], 23'($urandom)};
  endfunction

  // Drive one operation at a falling edge, check it at the next one.
  task automatic step(input logic [31:0] x, input logic [31:0] y, input logic op,
                      input logic [32:0] want, input string tag);
    a = x; b = y; sel = op;
    @(negedge clk);
    check(tag, {overflow, result}, want);
  endtask

  initial begin
    logic [31:0] x, y;
    logic        op;
    rst = 1'b1; a = 32'h3F80_0000; b = 32'h3F80_0000; sel = 1'b0;
    @(negedge clk);
    check("reset_c1", {overflow, result}, 33'h0_0000_0000);
    @(negedge clk);
    check("reset_c2", {overflow, result}, 33'h0_0000_0000);
    rst = 1'b0;
    step(32'h3F80_0000, 32'h3F80_0000, 1'b0, 33'h0_4000_0000, "rst_release");

    step(32'h0000_0000, 32'h0000_0000, 1'b0, 33'h0_0000_0000, "zero_add");
    step(32'h0000_0000, 32'h0000_0000, 1'b1, 33'h0_0000_0000, "zero_mul");
    step(32'h0000_0000, 32'h3F80_0000, 1'b0, 33'h0_3F80_0000, "zero_add_pos");
    step(32'h0000_0000, 32'h3F80_0000, 1'b1, 33'h0_0000_0000, "zero_mul_pos");
    step(32'h0000_0000, 32'hBF80_0000, 1'b0, 33'h0_BF80_0000, "zero_add_neg");
    step(32'h0000_0000, 32'hBF80_0000, 1'b1, 33'h0_0000_0000, "zero_mul_neg");
    step(32'hBF80_0000, 32'h8000_0000, 1'b0, 33'h0_BF80_0000, "add_b_zero");
    step(32'hBF00_0000, 32'hC0CC_CCCC, 1'b0, 33'h0_C0DC_CCCC, "add_align");
    step(32'h3F80_0000, 32'hBF80_0000, 1'b0, 33'h0_0000_0000, "cancel");
    step(32'h4040_0000, 32'hBF80_0000, 1'b0, 33'h0_4000_0000, "sub_norm");
    step(32'h3FC0_0000, 32'h4000_0000, 1'b1, 33'h0_4040_0000, "mul_norm");
    step(32'hBFC0_0000, 32'h3FC0_0000, 1'b1, 33'h0_C010_0000, "mul_neg");
    step(32'h7F00_0000, 32'h4000_0000, 1'b1, 33'h1_7F80_0000, "mul_ovf");
    step(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 33'h1_7F80_0000, "add_ovf");
    step(32'h0080_0000, 32'h0080_0000, 1'b1, 33'h0_0000_0000, "mul_unf");
    step(32'h7F80_0000, 32'h3F80_0000, 1'b0, 33'h1_7F80_0000, "inf_in");

    a = 32'h3FC0_0000; b = 32'h4000_0000; sel = 1'b1; rst = 1'b1;
    @(negedge clk);
    check("reset_prio", {overflow, result}, 33'h0_0000_0000);
    rst = 1'b0;

    for (int i = 0; i < 2000; i++) begin
      x  = rand_fp(0);
      y  = rand_fp(int'(x[30:23]));
      if ($urandom_range(0, 19) == 0) y = {~x[31], x[30:0]};
      op = 1'($urandom_range(0, 1));
      step(x, y, op, ref_model(x, y, op), op ? "rand_mul" : "rand_add");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/floating_point_alu.md
Name: floating_point_alu

Overview:
- Single-precision (IEEE-754 binary32) arithmetic unit with two operations: add (sel=0) and multiply (sel=1).
- Operates on normal numbers and zero.
- Result and overflow flag are registered: one-cycle latency, fully pipelined, one new operation accepted every clock.
- Sits in the datapath as a drop-in FP arithmetic stage.

Parameters:
- None. Format is fixed: 1 sign bit, 8 exponent bits, bias 127, 23 fraction bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- a  input  32  operand A, binary32
- b  input  32  operand B, binary32
- sel  input  1  0 = A+B, 1 = A*B
- result  output  32  registered binary32 result
- overflow  output  1  registered; 1 when the result exponent exceeds 254

Behaviour:
- Reset: at a rising clk edge with rst=1, result <= 32'h00000000 and overflow <= 0. Reset has priority; an operation presented in the same cycle is discarded.
- Latency: result and overflow reflect a, b and sel sampled at the previous rising edge. There is no handshake; the output is updated every cycle.
- Operand classification:
  - exponent 0 means zero; fraction ignored, so denormals flush to zero and the sign of a zero input is ignored.
  - exponent 1..254 means normal, with hidden 1.
  - exponent 255 is treated as an overflow input: result = ±inf (sign from normal rules), overflow=1.
- Add path (sel=0):
  - If A is zero, result = B exactly (B sign kept; zero B gives +0). Symmetric when B is zero.
  - Otherwise align the smaller-exponent significand right by the exponent difference. Shifted-out bits are dropped.
  - Same signs: add magnitudes; on carry-out, shift right 1 and exponent+1.
  - Different signs: subtract the smaller magnitude from the larger; sign is taken from the larger. Renormalize with a leading-zero count and left shift, decrementing the exponent.
  - Exact cancellation gives +0 (32'h00000000).
- Multiply path (sel=1):
  - Either operand zero gives +0 (32'h00000000), overflow=0, regardless of signs.
  - Sign = sa XOR sb. Exponent = ea + eb - 127, computed at 10-bit signed width.
  - Form the 24x24 significand product; if bit 47 is set, take bits [46:24] as the fraction and increment the exponent; else take bits [45:23].
- Rounding: truncation (round toward zero) on both paths; no guard/sticky bits are required.
- Overflow: final exponent >= 255 gives result = {sign, 8'hFF, 23'h0} and overflow=1.
- Underflow: final exponent <= 0 gives result = +0 and overflow=0.
- In all other cases overflow=0.
- No NaN generation, no exception flags other than overflow.

Decomposition:
- Shared package fp32_pkg holds:
  - constants FP_BIAS=127, FP_EXP_MAX=255, FP_FRAC_W=23, FP_EXP_W=8;
  - OP_ADD=1'b0, OP_MUL=1'b1;
  - a packed struct type for {sign, exp, frac}.
- One natural sub-module: fp_normalize, which takes a 25-bit magnitude and a 10-bit exponent and returns the normalized fraction and exponent (leading-zero count and shift). It is used by the add path; the multiply path uses its 1-bit normalization inline.
- Top level holds:
  - operand classification;
  - the add and multiply datapaths;
  - the sel mux;
  - overflow/underflow saturation;
  - the output register.

Test Plan:
- Reset: assert rst for 2 cycles with a=3F800000, b=3F800000 -> result=00000000, overflow=0. Deassert rst -> next cycle result=40000000 (sel=0).
- Zero handling:
  - a=00000000, b=00000000: sel=0 -> 00000000; sel=1 -> 00000000.
  - a=00000000, b=3F800000: add -> 3F800000; mul -> 00000000.
  - a=00000000, b=BF800000: add -> BF800000; mul -> 00000000.
  - All with overflow=0.
- Same-sign add with alignment: a=BF000000 (-0.5), b=C0CCCCCC (-6.3999996), sel=0 -> C0DCCCCC, overflow=0.
- Cancellation and normalization:
  - a=3F800000, b=BF800000, sel=0 -> 00000000.
  - a=40400000 (3.0), b=BF800000 (-1.0), sel=0 -> 40000000.
- Multiply normal: a=3FC00000 (1.5), b=40000000 (2.0), sel=1 -> 40400000. Also a=BFC00000, b=3FC00000 -> C0100000 (-2.25).
- Overflow/underflow and throughput:
  - a=7F000000, b=40000000, sel=1 -> 7F800000, overflow=1.
  - a=7F7FFFFF, b=7F7FFFFF, sel=0 -> 7F800000, overflow=1.
  - a=00800000, b=00800000, sel=1 -> 00000000, overflow=0.
  - Back-to-back different ops every cycle, with each output checked one cycle later.
